csr_multi_buffer: RTL



---
 rtl/csr_multi_buffer_pkg.sv | 34 +++
 rtl/csr_multi_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/csr_multi_buffer_pkg.sv
// Shared types for the CSR commit buffer: functional-unit operand bundle,
// stored entry layout and the FIFO operation decode.
package csr_multi_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned CSR_ADDR_BITS = 12;

    typedef logic [XLEN-1:0]          xlen_t;
    typedef logic [TRANS_ID_BITS-1:0] trans_id_t;

    typedef struct packed {
        xlen_t     operand_a;
        xlen_t     operand_b;
        trans_id_t trans_id;
    } fu_data_t;

    typedef struct packed {
        logic [CSR_ADDR_BITS-1:0] addr;
        trans_id_t                trans_id;
    } csr_buf_entry_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } fifo_op_e;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/csr_multi_buffer.sv
// Multi-entry CSR address buffer between issue and commit: a circular FIFO of
// {addr, trans_id} that lets issue run ahead of commit by several CSR ops.
module csr_multi_buffer
    import csr_multi_buffer_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic                             flush_i,
    input  fu_data_t                         fu_data_i,
    output logic                             csr_ready_o,
    input  logic                             csr_valid_i,
    output xlen_t                            csr_result_o,
    input  logic                             csr_commit_i,
    output logic [CSR_ADDR_BITS-1:0]         csr_addr_o,
    output logic [TRANS_ID_BITS-1:0]         csr_trans_id_o,
    output logic                             csr_head_valid_o,
    output logic [$clog2(NR_ENTRIES+1)-1:0]  csr_count_o
);

    // A single-entry buffer still needs a 1-bit pointer; it is simply held at 0.
    localparam int unsigned PTR_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NR_ENTRIES);

    function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] ptr);
        if (NR_ENTRIES == 1) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    csr_buf_entry_t   mem_q [NR_ENTRIES];
    csr_buf_entry_t   new_entry;

    logic     empty;
    logic     full;
    logic     push;
    logic     pop;
    logic     discard;
    fifo_op_e op;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign discard = flush_i || clr_i;

    // A full buffer committing this cycle frees its head, so it can take a push.
    assign csr_ready_o  = !full || (csr_commit_i && !empty);
    assign push         = csr_valid_i && csr_ready_o;
    assign pop          = csr_commit_i && !empty;
    assign csr_result_o = fu_data_i.operand_a;

    assign new_entry.addr     = fu_data_i.operand_b[CSR_ADDR_BITS-1:0];
    assign new_entry.trans_id = fu_data_i.trans_id;

    logic unused_operand_b;
    assign unused_operand_b = ^fu_data_i.operand_b[XLEN-1:CSR_ADDR_BITS];

    always_comb begin
        op = OP_NONE;
        if (push && pop) begin
            op = OP_BOTH;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        unique case (op)
            OP_PUSH: begin
                wr_ptr_d = ptr_incr(wr_ptr_q);
                count_d  = count_q + CNT_W'(1);
            end
            OP_POP: begin
                rd_ptr_d = ptr_incr(rd_ptr_q);
                count_d  = count_q - CNT_W'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = ptr_incr(wr_ptr_q);
                rd_ptr_d = ptr_incr(rd_ptr_q);
            end
            default: begin
            end
        endcase
        // Flush and clear win over any push or commit in the same cycle.
        if (discard) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flush leaves stale entries behind; only clear wipes the storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign csr_head_valid_o = !empty;
    assign csr_addr_o       = empty ? '0 : mem_q[rd_ptr_q].addr;
    assign csr_trans_id_o   = empty ? '0 : mem_q[rd_ptr_q].trans_id;
    assign csr_count_o      = count_q;

    a_push_when_ready : assert property (
        @(posedge clk_i) disable iff (!rst_ni) csr_valid_i |-> csr_ready_o
    ) else $error("csr_multi_buffer: CSR op issued while buffer not ready, op dropped");

    a_commit_not_empty : assert property (
        @(posedge clk_i) disable iff (!rst_ni) csr_commit_i |-> !empty
    ) else $error("csr_multi_buffer: commit while buffer empty ignored");

    a_depth_pow2 : assert property (
        @(posedge clk_i) is_pow2(NR_ENTRIES)
    ) else $error("csr_multi_buffer: NR_ENTRIES must be a power of two");

endmodule
